// File: rtl/board_tile_locator_if.sv
// Signal bundle between the VGA timing/game logic (master) and the tile locator (slave).
interface board_tile_locator_if;
  logic [11:0] pix_h;
  logic [11:0] pix_v;
  logic        de_in;
  logic        hs_in;
  logic        vs_in;
  logic [63:0] board;
  logic        board_valid;
  logic        board_ready;
  logic [3:0]  tile_state;
  logic [11:0] tile_h;
  logic [11:0] tile_v;
  logic        tile_active;
  logic [11:0] block_rgb;
  logic [11:0] rgb_out;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        commit;

  modport slave (
    input  pix_h, pix_v, de_in, hs_in, vs_in, board, board_valid, block_rgb,
    output board_ready, tile_state, tile_h, tile_v, tile_active,
           rgb_out, hs_out, vs_out, de_out, commit
  );

  modport master (
    output pix_h, pix_v, de_in, hs_in, vs_in, board, board_valid, block_rgb,
    input  board_ready, tile_state, tile_h, tile_v, tile_active,
           rgb_out, hs_out, vs_out, de_out, commit
  );
endinterface

// File: rtl/board_tile_locator.sv
// Maps global pixel counters onto the 4x4 board tiles, feeds the block renderer and
// composites its output with frame/background colours; board swaps happen only at vblank.
module board_tile_locator #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          V_ACTIVE    = 768,
  parameter int          GRID_X0     = 186,
  parameter int          GRID_Y0     = 58,
  parameter int          TILE        = 148,
  parameter int          GAP         = 12,
  parameter int          BLOCK_LAT   = 3,
  parameter logic [11:0] FRAME_COLOR = 12'hBAA,
  parameter logic [11:0] BG_COLOR    = 12'hFFE
) (
  input  logic                  clk,
  input  logic                  rst,
  board_tile_locator_if.slave   tl_io
);

  localparam int PITCH = TILE + GAP;
  localparam int SPAN  = 4 * TILE + 5 * GAP;

  typedef enum logic [1:0] {
    REG_OUT   = 2'd0,
    REG_FRAME = 2'd1,
    REG_TILE  = 2'd2
  } region_e;

  // ---------------- per-axis tile hit detection ----------------
  logic [3:0]  col_hit;
  logic [3:0]  row_hit;
  logic [11:0] col_off [4];
  logic [11:0] row_off [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_axis
      localparam logic [11:0] START_X = 12'(GRID_X0 + GAP + gi * PITCH);
      localparam logic [11:0] START_Y = 12'(GRID_Y0 + GAP + gi * PITCH);
      assign col_hit[gi] = (tl_io.pix_h >= START_X) && (tl_io.pix_h < START_X + 12'(TILE));
      assign row_hit[gi] = (tl_io.pix_v >= START_Y) && (tl_io.pix_v < START_Y + 12'(TILE));
      assign col_off[gi] = tl_io.pix_h - START_X;
      assign row_off[gi] = tl_io.pix_v - START_Y;
    end
  endgenerate

  logic in_area;
  logic in_board;
  assign in_area  = (tl_io.pix_h < 12'(H_ACTIVE)) && (tl_io.pix_v < 12'(V_ACTIVE));
  assign in_board = (tl_io.pix_h >= 12'(GRID_X0)) && (tl_io.pix_h < 12'(GRID_X0 + SPAN)) &&
                    (tl_io.pix_v >= 12'(GRID_Y0)) && (tl_io.pix_v < 12'(GRID_Y0 + SPAN));

  // ---------------- board double buffer ----------------
  logic [63:0] shadow_q;
  logic [63:0] pending_q;
  logic        pending_flag_q;
  logic        board_ready_q;
  logic        commit_q;
  logic        commit_pt;

  assign commit_pt = (tl_io.pix_h == 12'd0) && (tl_io.pix_v == 12'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      board_ready_q  <= 1'b1;
      commit_q       <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      // A capture needs ready (flag clear) and a commit needs the flag set, so they never coincide.
      if (commit_pt && pending_flag_q) begin
        shadow_q       <= pending_q;
        pending_flag_q <= 1'b0;
        board_ready_q  <= 1'b1;
        commit_q       <= 1'b1;
      end else if (tl_io.board_valid && board_ready_q) begin
        pending_q      <= tl_io.board;
        pending_flag_q <= 1'b1;
        board_ready_q  <= 1'b0;
      end
    end
  end

  // ---------------- stage 1 decode ----------------
  region_e     region_d;
  logic        tile_active_d;
  logic [11:0] tile_h_d;
  logic [11:0] tile_v_d;
  logic [3:0]  tile_state_d;
  logic [11:0] h_sel;
  logic [11:0] v_sel;
  logic [1:0]  col_sel;
  logic [1:0]  row_sel;

  always_comb begin
    region_d      = REG_OUT;
    tile_active_d = 1'b0;
    tile_h_d      = '0;
    tile_v_d      = '0;
    tile_state_d  = '0;
    h_sel         = '0;
    v_sel         = '0;
    col_sel       = '0;
    row_sel       = '0;
    for (int c = 0; c < 4; c++) begin
      if (col_hit[c]) begin
        h_sel   = col_off[c];
        col_sel = 2'(c);
      end
      if (row_hit[c]) begin
        v_sel   = row_off[c];
        row_sel = 2'(c);
      end
    end
    if (in_area && tl_io.de_in && in_board) begin
      if ((|col_hit) && (|row_hit)) begin
        region_d      = REG_TILE;
        tile_active_d = 1'b1;
        tile_h_d      = h_sel;
        tile_v_d      = v_sel;
        tile_state_d  = shadow_q[{row_sel, col_sel, 2'b00} +: 4];
      end else begin
        region_d = REG_FRAME;
      end
    end
  end

  region_e     region_q;
  logic        tile_active_q;
  logic [11:0] tile_h_q;
  logic [11:0] tile_v_q;
  logic [3:0]  tile_state_q;
  logic        de_s1_q;
  logic        hs_s1_q;
  logic        vs_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      region_q      <= REG_OUT;
      tile_active_q <= 1'b0;
      tile_h_q      <= '0;
      tile_v_q      <= '0;
      tile_state_q  <= '0;
      de_s1_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
    end else begin
      region_q      <= region_d;
      tile_active_q <= tile_active_d;
      tile_h_q      <= tile_h_d;
      tile_v_q      <= tile_v_d;
      tile_state_q  <= tile_state_d;
      de_s1_q       <= tl_io.de_in;
      hs_s1_q       <= tl_io.hs_in;
      vs_s1_q       <= tl_io.vs_in;
    end
  end

  // ---------------- delay line matching the renderer latency ----------------
  region_e region_dly_q [BLOCK_LAT];
  logic    de_dly_q     [BLOCK_LAT];
  logic    hs_dly_q     [BLOCK_LAT];
  logic    vs_dly_q     [BLOCK_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BLOCK_LAT; k++) begin
        region_dly_q[k] <= REG_OUT;
        de_dly_q[k]     <= 1'b0;
        hs_dly_q[k]     <= 1'b0;
        vs_dly_q[k]     <= 1'b0;
      end
    end else begin
      region_dly_q[0] <= region_q;
      de_dly_q[0]     <= de_s1_q;
      hs_dly_q[0]     <= hs_s1_q;
      vs_dly_q[0]     <= vs_s1_q;
      for (int k = 1; k < BLOCK_LAT; k++) begin
        region_dly_q[k] <= region_dly_q[k-1];
        de_dly_q[k]     <= de_dly_q[k-1];
        hs_dly_q[k]     <= hs_dly_q[k-1];
        vs_dly_q[k]     <= vs_dly_q[k-1];
      end
    end
  end

  // ---------------- output compositing ----------------
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;
  logic        hs_out_q;
  logic        vs_out_q;
  logic        de_out_q;

  always_comb begin
    rgb_d = '0;
    if (de_dly_q[BLOCK_LAT-1]) begin
      case (region_dly_q[BLOCK_LAT-1])
        REG_TILE:  rgb_d = tl_io.block_rgb;
        REG_FRAME: rgb_d = FRAME_COLOR;
        default:   rgb_d = BG_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= '0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
      de_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs_out_q <= hs_dly_q[BLOCK_LAT-1];
      vs_out_q <= vs_dly_q[BLOCK_LAT-1];
      de_out_q <= de_dly_q[BLOCK_LAT-1];
    end
  end

  assign tl_io.board_ready = board_ready_q;
  assign tl_io.commit      = commit_q;
  assign tl_io.tile_active = tile_active_q;
  assign tl_io.tile_h      = tile_h_q;
  assign tl_io.tile_v      = tile_v_q;
  assign tl_io.tile_state  = tile_state_q;
  assign tl_io.rgb_out     = rgb_q;
  assign tl_io.hs_out      = hs_out_q;
  assign tl_io.vs_out      = vs_out_q;
  assign tl_io.de_out      = de_out_q;

endmodule

// File: tb/tb_board_tile_locator.sv
// Self-checking bench for board_tile_locator: hand-computed vectors, directed handshake
// sequences and randomized pixels checked against an arithmetic reference model.
module tb_board_tile_locator;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int GRID_X0  = 186;
  localparam int GRID_Y0  = 58;
  localparam int TILE     = 148;
  localparam int GAP      = 12;
  localparam int PITCH    = TILE + GAP;
  localparam int SPAN     = 4 * TILE + 5 * GAP;
  localparam int LAT      = 5;

  logic clk;
  logic rst;
  board_tile_locator_if tl_if ();

  board_tile_locator dut (
    .clk   (clk),
    .rst   (rst),
    .tl_io (tl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  region;  // 0 outside, 1 frame, 2 tile
    logic        act;
    logic [11:0] th;
    logic [11:0] tv;
    logic [3:0]  st;
    logic        de;
    logic        hs;
    logic        vs;
  } s1_t;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        de;
    logic        act;
    logic [11:0] th;
    logic [11:0] tv;
    logic [3:0]  st;
    logic [11:0] rgb;
  } vec_t;

  logic [63:0] m_shadow;
  logic [63:0] m_pending;
  logic        m_flag;
  s1_t         pipe_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic s1_t model_decode(input int h, input int v, input logic de, input logic [63:0] sh);
    s1_t r;
    int rx, ry, col, row;
    r  = '0;
    rx = h - GRID_X0;
    ry = v - GRID_Y0;
    if (de && h < H_ACTIVE && v < V_ACTIVE && rx >= 0 && rx < SPAN && ry >= 0 && ry < SPAN) begin
      if ((rx % PITCH) >= GAP && (ry % PITCH) >= GAP) begin
        col      = rx / PITCH;
        row      = ry / PITCH;
        r.region = 2'd2;
        r.act    = 1'b1;
        r.th     = 12'((rx % PITCH) - GAP);
        r.tv     = 12'((ry % PITCH) - GAP);
        r.st     = sh[4*(row*4+col) +: 4];
      end else begin
        r.region = 2'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] rgb_of(input s1_t e, input logic [11:0] blk);
    if (!e.de) return 12'h000;
    case (e.region)
      2'd2:    return blk;
      2'd1:    return 12'hBAA;
      default: return 12'hFFE;
    endcase
  endfunction

  task automatic model_reset();
    m_shadow  = '0;
    m_pending = '0;
    m_flag    = 1'b0;
    pipe_q.delete();
  endtask

  // One clock: predict from the current inputs, advance, compare on the falling edge.
  task automatic tick();
    s1_t         e;
    s1_t         old;
    logic [11:0] exp_rgb;
    logic        exp_hs, exp_vs, exp_de, exp_commit, cp;
    e    = model_decode(int'(tl_if.pix_h), int'(tl_if.pix_v), tl_if.de_in, m_shadow);
    e.de = tl_if.de_in;
    e.hs = tl_if.hs_in;
    e.vs = tl_if.vs_in;
    pipe_q.push_back(e);
    exp_rgb = '0; exp_hs = 1'b0; exp_vs = 1'b0; exp_de = 1'b0;
    if (pipe_q.size() >= LAT) begin
      old     = pipe_q.pop_front();
      exp_rgb = rgb_of(old, tl_if.block_rgb);
      exp_hs  = old.hs;
      exp_vs  = old.vs;
      exp_de  = old.de;
    end
    cp         = (tl_if.pix_h == 12'd0) && (tl_if.pix_v == 12'(V_ACTIVE));
    exp_commit = cp && m_flag;
    if (exp_commit) begin
      m_shadow = m_pending;
      m_flag   = 1'b0;
    end else if (tl_if.board_valid && !m_flag) begin
      m_pending = tl_if.board;
      m_flag    = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("tile_active", 64'(tl_if.tile_active), 64'(e.act));
    check("tile_h",      64'(tl_if.tile_h),      64'(e.th));
    check("tile_v",      64'(tl_if.tile_v),      64'(e.tv));
    check("tile_state",  64'(tl_if.tile_state),  64'(e.st));
    check("rgb_out",     64'(tl_if.rgb_out),     64'(exp_rgb));
    check("hs_out",      64'(tl_if.hs_out),      64'(exp_hs));
    check("vs_out",      64'(tl_if.vs_out),      64'(exp_vs));
    check("de_out",      64'(tl_if.de_out),      64'(exp_de));
    check("commit",      64'(tl_if.commit),      64'(exp_commit));
    check("board_ready", 64'(tl_if.board_ready), 64'(!m_flag));
  endtask

  task automatic set_pix(input int h, input int v, input logic de);
    tl_if.pix_h = 12'(h);
    tl_if.pix_v = 12'(v);
    tl_if.de_in = de;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 64'(tl_if.tile_active), 64'(0));
    check({tag, "_th"},     64'(tl_if.tile_h),      64'(0));
    check({tag, "_tv"},     64'(tl_if.tile_v),      64'(0));
    check({tag, "_state"},  64'(tl_if.tile_state),  64'(0));
    check({tag, "_rgb"},    64'(tl_if.rgb_out),     64'(0));
    check({tag, "_hs"},     64'(tl_if.hs_out),      64'(0));
    check({tag, "_vs"},     64'(tl_if.vs_out),      64'(0));
    check({tag, "_de"},     64'(tl_if.de_out),      64'(0));
    check({tag, "_commit"}, 64'(tl_if.commit),      64'(0));
    check({tag, "_ready"},  64'(tl_if.board_ready), 64'(1));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs [16];
  logic [63:0] brd_a, brd_b, brd_c;

  initial begin
    for (int i = 0; i < 16; i++) brd_a[4*i +: 4] = 4'(i + 3);
    brd_b = {$urandom, $urandom};
    brd_c = {$urandom, $urandom};
    if (brd_c == brd_b) brd_c = ~brd_b;

    //          h      v      de    act   th      tv      st     rgb
    vecs[0]  = '{12'd203, 12'd77,  1'b1, 1'b1, 12'd5,   12'd7,   4'h3, 12'h123};
    vecs[1]  = '{12'd197, 12'd77,  1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hBAA};
    vecs[2]  = '{12'd198, 12'd70,  1'b1, 1'b1, 12'd0,   12'd0,   4'h3, 12'h123};
    vecs[3]  = '{12'd345, 12'd217, 1'b1, 1'b1, 12'd147, 12'd147, 4'h3, 12'h123};
    vecs[4]  = '{12'd346, 12'd100, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hBAA};
    vecs[5]  = '{12'd358, 12'd230, 1'b1, 1'b1, 12'd0,   12'd0,   4'h8, 12'h123};
    vecs[6]  = '{12'd825, 12'd697, 1'b1, 1'b1, 12'd147, 12'd147, 4'h2, 12'h123};
    vecs[7]  = '{12'd826, 12'd697, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hBAA};
    vecs[8]  = '{12'd838, 12'd697, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hFFE};
    vecs[9]  = '{12'd185, 12'd100, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hFFE};
    vecs[10] = '{12'd186, 12'd58,  1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hBAA};
    vecs[11] = '{12'd203, 12'd77,  1'b0, 1'b0, 12'd0,   12'd0,   4'h0, 12'h000};
    vecs[12] = '{12'd1030, 12'd77, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hFFE};
    vecs[13] = '{12'd500, 12'd800, 1'b1, 1'b0, 12'd0,   12'd0,   4'h0, 12'hFFE};
    vecs[14] = '{12'd678, 12'd550, 1'b1, 1'b1, 12'd0,   12'd0,   4'h2, 12'h123};
    vecs[15] = '{12'd518, 12'd390, 1'b1, 1'b1, 12'd0,   12'd0,   4'hD, 12'h123};

    // ---- reset ----
    rst = 1'b1;
    set_pix(0, 0, 1'b0);
    tl_if.hs_in = 1'b0; tl_if.vs_in = 1'b0;
    tl_if.board = '0; tl_if.board_valid = 1'b0; tl_if.block_rgb = 12'h123;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // ---- commit board A ----
    set_pix(400, 300, 1'b1);
    tl_if.board = brd_a; tl_if.board_valid = 1'b1;
    tick();
    tl_if.board_valid = 1'b0;
    set_pix(0, V_ACTIVE, 1'b0);
    tick();
    check("commit_a_pulse", 64'(tl_if.commit), 64'(1));
    set_pix(1, V_ACTIVE, 1'b0);
    tick();

    // ---- geometry table ----
    for (int i = 0; i < 16; i++) begin
      set_pix(int'(vecs[i].h), int'(vecs[i].v), vecs[i].de);
      tl_if.hs_in = 1'(i); tl_if.block_rgb = 12'h123;
      tick();
      check($sformatf("vec%0d_active", i), 64'(tl_if.tile_active), 64'(vecs[i].act));
      check($sformatf("vec%0d_th", i),     64'(tl_if.tile_h),      64'(vecs[i].th));
      check($sformatf("vec%0d_tv", i),     64'(tl_if.tile_v),      64'(vecs[i].tv));
      check($sformatf("vec%0d_state", i),  64'(tl_if.tile_state),  64'(vecs[i].st));
      repeat (LAT - 1) tick();
      check($sformatf("vec%0d_rgb", i),    64'(tl_if.rgb_out),     64'(vecs[i].rgb));
    end

    // ---- full line sweep inside row 2 ----
    for (int h = 0; h < 1200; h++) begin
      set_pix(h, 400, 1'(h < H_ACTIVE));
      tl_if.hs_in = 1'(h >= 1048 && h < 1184);
      tick();
    end

    // ---- mid-frame board offer, second offer ignored while pending ----
    set_pix(400, 300, 1'b1);
    tl_if.board = brd_b; tl_if.board_valid = 1'b1;
    tick();
    check("ready_drop", 64'(tl_if.board_ready), 64'(0));
    tl_if.board = brd_c;
    for (int k = 0; k < 16; k++) begin
      set_pix(GRID_X0 + GAP + (k % 4) * PITCH + 20, GRID_Y0 + GAP + (k / 4) * PITCH + 30, 1'b1);
      tick();
    end
    tl_if.board_valid = 1'b0;
    set_pix(GRID_X0 + GAP + 3, GRID_Y0 + GAP + 4, 1'b1);
    tick();
    check("old_board_idx0", 64'(tl_if.tile_state), 64'(brd_a[3:0]));
    set_pix(0, V_ACTIVE, 1'b0);
    tick();
    check("commit_b_pulse", 64'(tl_if.commit), 64'(1));
    check("ready_back", 64'(tl_if.board_ready), 64'(1));
    set_pix(GRID_X0 + GAP + 3, GRID_Y0 + GAP + 4, 1'b1);
    tick();
    check("new_board_idx0", 64'(tl_if.tile_state), 64'(brd_b[3:0]));
    for (int k = 0; k < 16; k++) begin
      set_pix(GRID_X0 + GAP + (k % 4) * PITCH + 100, GRID_Y0 + GAP + (k / 4) * PITCH + 9, 1'b1);
      tick();
    end

    // ---- valid exactly on the commit cycle with nothing pending ----
    set_pix(0, V_ACTIVE, 1'b0);
    tl_if.board = brd_c; tl_if.board_valid = 1'b1;
    tick();
    check("no_commit_same_cycle", 64'(tl_if.commit), 64'(0));
    check("captured_on_commit_pt", 64'(tl_if.board_ready), 64'(0));
    tl_if.board_valid = 1'b0;
    set_pix(GRID_X0 + GAP, GRID_Y0 + GAP, 1'b1);
    tick();
    check("still_board_b", 64'(tl_if.tile_state), 64'(brd_b[3:0]));
    set_pix(0, V_ACTIVE, 1'b0);
    tick();
    check("commit_c_pulse", 64'(tl_if.commit), 64'(1));
    set_pix(GRID_X0 + GAP, GRID_Y0 + GAP, 1'b1);
    tick();
    check("board_c_idx0", 64'(tl_if.tile_state), 64'(brd_c[3:0]));

    // ---- randomized pixels / handshake ----
    for (int n = 0; n < 3000; n++) begin
      int h, v;
      if ($urandom_range(0, 39) == 0) begin
        h = 0; v = V_ACTIVE;
      end else if ($urandom_range(0, 9) < 7) begin
        h = int'($urandom_range(GRID_X0 - 6, GRID_X0 + SPAN + 6));
        v = int'($urandom_range(GRID_Y0 - 6, GRID_Y0 + SPAN + 6));
      end else begin
        h = int'($urandom_range(0, 1100));
        v = int'($urandom_range(0, 800));
      end
      set_pix(h, v, ($urandom_range(0, 9) == 0) ? 1'($urandom) : 1'(h < H_ACTIVE && v < V_ACTIVE));
      tl_if.hs_in       = 1'($urandom);
      tl_if.vs_in       = 1'($urandom);
      tl_if.block_rgb   = 12'($urandom);
      tl_if.board_valid = ($urandom_range(0, 7) == 0);
      tl_if.board       = {$urandom, $urandom};
      tick();
    end
    tl_if.board_valid = 1'b0;

    // ---- asynchronous reset mid-line ----
    tl_if.board = brd_a; tl_if.board_valid = 1'b1;
    set_pix(203, 77, 1'b1);
    tl_if.hs_in = 1'b1; tl_if.vs_in = 1'b1; tl_if.block_rgb = 12'h456;
    tick();
    tl_if.board_valid = 1'b0;
    repeat (LAT + 1) tick();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    tl_if.hs_in = 1'b0; tl_if.vs_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      set_pix(GRID_X0 + GAP + (k % 4) * PITCH + 50, GRID_Y0 + GAP + (k / 4) * PITCH + 60, 1'b1);
      tick();
      check($sformatf("post_rst_state%0d", k), 64'(tl_if.tile_state), 64'(0));
    end
    repeat (LAT) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
